// File: rtl/block_char_filter_pkg.sv
// block_char_pkg: character constants, FSM state encoding and classification helpers for block_char_filter
package block_char_pkg;
   localparam logic [7:0] C_SP    = 8'h20;
   localparam logic [7:0] C_TAB   = 8'h09;
   localparam logic [7:0] C_LF    = 8'h0A;
   localparam logic [7:0] C_CR    = 8'h0D;
   localparam logic [7:0] C_SLASH = 8'h2F;
   typedef enum logic [1:0] {S_SPACE, S_WORD, S_SLASH, S_COMMENT} state_t;
   function automatic logic [7:0] to_lower(input logic [7:0] c);
      return (c >= 8'h41 && c <= 8'h5A) ? c + 8'h20 : c;
   endfunction
   function automatic logic is_ws(input logic [7:0] c);
      return c == C_SP || c == C_TAB || c == C_LF || c == C_CR;
   endfunction
endpackage

// File: rtl/block_char_filter_if.sv
// block_char_filter_if: raw input and filtered output byte-stream handshakes
interface block_char_filter_if;
   logic       in_valid, in_ready, out_valid, out_ready;
   logic [7:0] in_char, out_char;
   modport master(output in_valid, in_char, out_ready, input in_ready, out_valid, out_char);
   modport slave(input in_valid, in_char, out_ready, output in_ready, out_valid, out_char);
endinterface

// File: rtl/block_char_filter_char_fifo2.sv
// char_fifo2: byte FIFO taking up to two pushes (slot 0 first) and one pop per cycle
module char_fifo2 #(
   parameter int DEPTH = 4,
   parameter int AW = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push0,
   input  logic          push1,
   input  logic [7:0]    data0,
   input  logic [7:0]    data1,
   input  logic          pop,
   output logic [7:0]    head,
   output logic [AW:0]   count
);
   localparam int CW = AW + 1;
   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr, rd;
   logic          pop_ok;
   assign pop_ok = pop && count != '0;
   assign head = count == '0 ? 8'h00 : mem[rd];
   always_ff @(posedge clk) begin
      if (reset) begin
         wr    <= '0;
         rd    <= '0;
         count <= '0;
      end else begin
         if (push0) mem[wr] <= data0;
         if (push1) mem[push0 ? wr + AW'(1) : wr] <= data1;
         wr    <= wr + AW'(push0) + AW'(push1);
         rd    <= rd + AW'(pop_ok);
         count <= count + CW'(push0) + CW'(push1) - CW'(pop_ok);
      end
   end
endmodule

// File: rtl/block_char_filter.sv
// block_char_filter: folds case, collapses whitespace and strips // comments ahead of the block checker
module block_char_filter
   import block_char_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW = 2
) (
   input  logic                clk,
   input  logic                reset,
   block_char_filter_if.slave  bus,
   output logic [15:0]         word_cnt
);
   localparam int CW = AW + 1;
   state_t      state, nstate;
   logic        sep_pend, nsep, last_sp, last0, nlast, acc, p0, p1;
   logic [7:0]  c, d0, d1;
   logic [AW:0] count;
   logic [1:0]  inc;
   logic [16:0] sum;
   assign bus.in_ready  = (CW'(DEPTH) - count) >= CW'(2);
   assign bus.out_valid = count != '0;
   assign acc = bus.in_valid && bus.in_ready;
   assign c   = to_lower(bus.in_char);
   always_comb begin
      nstate = state;
      nsep   = sep_pend;
      p0     = 1'b0;
      p1     = 1'b0;
      d0     = c;
      d1     = c;
      if (acc) begin
         case (state)
            S_SPACE: begin
               if (c == C_SLASH) begin
                  nstate = S_SLASH;
                  nsep   = 1'b0;
               end else if (!is_ws(c)) begin
                  p0     = 1'b1;
                  nstate = S_WORD;
               end
            end
            S_WORD: begin
               if (c == C_SLASH) begin
                  nstate = S_SLASH;
                  nsep   = 1'b1;
               end else begin
                  p0     = 1'b1;
                  d0     = is_ws(c) ? C_SP : c;
                  nstate = is_ws(c) ? S_SPACE : S_WORD;
               end
            end
            S_SLASH: begin
               // a lone '/' is released together with whatever byte resolved it
               if (c == C_SLASH) nstate = S_COMMENT;
               else begin
                  p0     = 1'b1;
                  p1     = 1'b1;
                  d0     = C_SLASH;
                  d1     = is_ws(c) ? C_SP : c;
                  nstate = is_ws(c) ? S_SPACE : S_WORD;
               end
            end
            default: begin
               if (c == C_LF) begin
                  p0     = sep_pend;
                  d0     = C_SP;
                  nstate = S_SPACE;
               end
            end
         endcase
      end
   end
   assign last0 = p0 ? d0 == C_SP : last_sp;
   assign nlast = p1 ? d1 == C_SP : last0;
   assign inc   = {1'b0, p0 && d0 != C_SP && last_sp} + {1'b0, p1 && d1 != C_SP && last0};
   assign sum   = {1'b0, word_cnt} + 17'(inc);
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_SPACE;
         sep_pend <= 1'b0;
         last_sp  <= 1'b1;
         word_cnt <= '0;
      end else begin
         state    <= nstate;
         sep_pend <= nsep;
         last_sp  <= nlast;
         word_cnt <= sum[16] ? 16'hFFFF : sum[15:0];
      end
   end
   char_fifo2 #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push0 (p0),
      .push1 (p1),
      .data0 (d0),
      .data1 (d1),
      .pop   (bus.out_ready),
      .head  (bus.out_char),
      .count (count)
   );
endmodule
